// File: rtl/control_unit.sv
// Hardwired control sequencer for the bus-based CPU datapath: fetch (T0-T2) plus opcode-driven execute (T3-T7).
// Optional macro MUL_DIV_EN enables the mul/div sequence; without it those opcodes decode as nop.
module control_unit #(
    parameter int unsigned T_WIDTH = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR_Data,
    input  logic        con_output,
    output logic        PC_enable,
    output logic        PC_increment_enable,
    output logic        IR_enable,
    output logic        con_enable,
    output logic        Y_enable,
    output logic        Z_enable,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        HI_enable,
    output logic        LO_enable,
    output logic        read,
    output logic        write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        r_enable,
    output logic        r_select,
    output logic        BAout,
    output logic        PC_select,
    output logic        HI_select,
    output logic        LO_select,
    output logic        Z_HI_select,
    output logic        Z_LO_select,
    output logic        MDR_select,
    output logic        InPort_select,
    output logic        c_select,
    output logic [4:0]  alu_instruction,
    output logic        halted
);

    typedef enum logic [T_WIDTH-1:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        K_NOP, K_ALU, K_IMM, K_UNARY, K_MULDIV, K_LD, K_LDI, K_ST,
        K_BR, K_JR, K_MFHI, K_MFLO, K_HALT
    } kind_t;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    state_t     state_q, state_d;
    kind_t      kind;
    logic [4:0] opcode;
    logic [4:0] imm_op;
    logic       unused_ir;

    assign opcode    = IR_Data[31:27];
    assign unused_ir = ^IR_Data[26:0];

    // Instruction class from the opcode field
    always_comb begin
        kind = K_NOP;
        if (opcode >= 5'b00011 && opcode <= 5'b01011) begin
            kind = K_ALU;
        end else begin
            case (opcode)
                5'b00000: kind = K_LD;
                5'b00001: kind = K_LDI;
                5'b00010: kind = K_ST;
                5'b01100, 5'b01101, 5'b01110: kind = K_IMM;
`ifdef MUL_DIV_EN
                5'b01111, 5'b10000: kind = K_MULDIV;
`else
                5'b01111, 5'b10000: kind = K_NOP;
`endif
                5'b10001, 5'b10010: kind = K_UNARY;
                5'b10011: kind = K_BR;
                5'b10100: kind = K_JR;
                5'b11000: kind = K_MFHI;
                5'b11001: kind = K_MFLO;
                5'b11011: kind = K_HALT;
                default:  kind = K_NOP;
            endcase
        end
    end

    always_comb begin
        case (opcode)
            5'b01101: imm_op = ALU_AND;
            5'b01110: imm_op = ALU_OR;
            default:  imm_op = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S_T0;
        end else begin
            state_q <= state_d;
        end
    end

    // Step sequencing; each class leaves the execute chain at its last listed step
    always_comb begin
        state_d = S_T0;
        case (state_q)
            S_T0: state_d = S_T1;
            S_T1: state_d = S_T2;
            S_T2: state_d = (kind == K_NOP) ? S_T0 : S_T3;
            S_T3: begin
                case (kind)
                    K_HALT: state_d = S_HALT;
                    K_ALU, K_IMM, K_UNARY, K_MULDIV,
                    K_LD, K_LDI, K_ST, K_BR: state_d = S_T4;
                    default: state_d = S_T0;
                endcase
            end
            S_T4: begin
                case (kind)
                    K_ALU, K_IMM, K_MULDIV, K_LD, K_LDI, K_ST, K_BR: state_d = S_T5;
                    default: state_d = S_T0;
                endcase
            end
            S_T5: begin
                case (kind)
                    K_MULDIV, K_LD, K_ST, K_BR: state_d = S_T6;
                    default: state_d = S_T0;
                endcase
            end
            S_T6:    state_d = (kind == K_LD || kind == K_ST) ? S_T7 : S_T0;
            S_T7:    state_d = S_T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_T0;
        endcase
    end

    // Control-step decode; everything is forced low while clr is asserted
    always_comb begin
        PC_enable           = 1'b0;
        PC_increment_enable = 1'b0;
        IR_enable           = 1'b0;
        con_enable          = 1'b0;
        Y_enable            = 1'b0;
        Z_enable            = 1'b0;
        MAR_enable          = 1'b0;
        MDR_enable          = 1'b0;
        HI_enable           = 1'b0;
        LO_enable           = 1'b0;
        read                = 1'b0;
        write               = 1'b0;
        Gra                 = 1'b0;
        Grb                 = 1'b0;
        Grc                 = 1'b0;
        r_enable            = 1'b0;
        r_select            = 1'b0;
        BAout               = 1'b0;
        PC_select           = 1'b0;
        HI_select           = 1'b0;
        LO_select           = 1'b0;
        Z_HI_select         = 1'b0;
        Z_LO_select         = 1'b0;
        MDR_select          = 1'b0;
        InPort_select       = 1'b0;
        c_select            = 1'b0;
        alu_instruction     = 5'b00000;
        halted              = 1'b0;
        if (clr) begin
            case (state_q)
                S_T0: begin
                    PC_select = 1'b1; MAR_enable = 1'b1; PC_increment_enable = 1'b1;
                end
                S_T1: begin
                    read = 1'b1; MDR_enable = 1'b1;
                end
                S_T2: begin
                    MDR_select = 1'b1; IR_enable = 1'b1;
                end
                S_T3: begin
                    case (kind)
                        K_ALU, K_IMM: begin
                            Grb = 1'b1; r_select = 1'b1; Y_enable = 1'b1;
                        end
                        K_UNARY: begin
                            Grb = 1'b1; r_select = 1'b1; alu_instruction = opcode; Z_enable = 1'b1;
                        end
                        K_MULDIV: begin
                            Gra = 1'b1; r_select = 1'b1; Y_enable = 1'b1;
                        end
                        K_LD, K_LDI, K_ST: begin
                            Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1;
                        end
                        K_BR: begin
                            Gra = 1'b1; r_select = 1'b1; con_enable = 1'b1;
                        end
                        K_JR: begin
                            Gra = 1'b1; r_select = 1'b1; PC_enable = 1'b1;
                        end
                        K_MFHI: begin
                            HI_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
                        end
                        K_MFLO: begin
                            LO_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T4: begin
                    case (kind)
                        K_ALU: begin
                            Grc = 1'b1; r_select = 1'b1; alu_instruction = opcode; Z_enable = 1'b1;
                        end
                        K_IMM: begin
                            c_select = 1'b1; alu_instruction = imm_op; Z_enable = 1'b1;
                        end
                        K_UNARY: begin
                            Z_LO_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
                        end
                        K_MULDIV: begin
                            Grb = 1'b1; r_select = 1'b1; alu_instruction = opcode; Z_enable = 1'b1;
                        end
                        K_LD, K_LDI, K_ST: begin
                            c_select = 1'b1; alu_instruction = ALU_ADD; Z_enable = 1'b1;
                        end
                        K_BR: begin
                            PC_select = 1'b1; Y_enable = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T5: begin
                    case (kind)
                        K_ALU, K_IMM, K_LDI: begin
                            Z_LO_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
                        end
`ifdef MUL_DIV_EN
                        K_MULDIV: begin
                            Z_LO_select = 1'b1; LO_enable = 1'b1;
                        end
`else
                        K_MULDIV: ;
`endif
                        K_LD, K_ST: begin
                            Z_LO_select = 1'b1; MAR_enable = 1'b1;
                        end
                        K_BR: begin
                            c_select = 1'b1; alu_instruction = ALU_ADD; Z_enable = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T6: begin
                    case (kind)
`ifdef MUL_DIV_EN
                        K_MULDIV: begin
                            Z_HI_select = 1'b1; HI_enable = 1'b1;
                        end
`else
                        K_MULDIV: ;
`endif
                        K_LD: begin
                            read = 1'b1; MDR_enable = 1'b1;
                        end
                        K_ST: begin
                            Gra = 1'b1; r_select = 1'b1; MDR_enable = 1'b1;
                        end
                        K_BR: begin
                            Z_LO_select = 1'b1; PC_enable = con_output;
                        end
                        default: ;
                    endcase
                end
                S_T7: begin
                    case (kind)
                        K_LD: begin
                            MDR_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
                        end
                        K_ST: write = 1'b1;
                        default: ;
                    endcase
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a per-instruction step-list model checked against the DUT every cycle, plus literal pins.
module tb_control_unit;

    typedef struct packed {
        logic       PC_enable;
        logic       PC_increment_enable;
        logic       IR_enable;
        logic       con_enable;
        logic       Y_enable;
        logic       Z_enable;
        logic       MAR_enable;
        logic       MDR_enable;
        logic       HI_enable;
        logic       LO_enable;
        logic       read;
        logic       write;
        logic       Gra;
        logic       Grb;
        logic       Grc;
        logic       r_enable;
        logic       r_select;
        logic       BAout;
        logic       PC_select;
        logic       HI_select;
        logic       LO_select;
        logic       Z_HI_select;
        logic       Z_LO_select;
        logic       MDR_select;
        logic       InPort_select;
        logic       c_select;
        logic [4:0] alu;
        logic       halted;
    } ctl_t;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] IR_Data;
    logic        con_output;
    logic PC_enable, PC_increment_enable, IR_enable, con_enable, Y_enable, Z_enable;
    logic MAR_enable, MDR_enable, HI_enable, LO_enable, read, write;
    logic Gra, Grb, Grc, r_enable, r_select, BAout;
    logic PC_select, HI_select, LO_select, Z_HI_select, Z_LO_select, MDR_select, InPort_select, c_select;
    logic [4:0] alu_instruction;
    logic halted;

    ctl_t  obs;
    ctl_t  exp_v;
    bit    exp_valid = 1'b0;
    string step_name = "";
    int    n_chk = 0;
    int    n_pass = 0;
    ctl_t  trace[$];
    ctl_t  plan[$];

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .clr(clr), .IR_Data(IR_Data), .con_output(con_output),
        .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable), .IR_enable(IR_enable),
        .con_enable(con_enable), .Y_enable(Y_enable), .Z_enable(Z_enable), .MAR_enable(MAR_enable),
        .MDR_enable(MDR_enable), .HI_enable(HI_enable), .LO_enable(LO_enable), .read(read),
        .write(write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .r_enable(r_enable), .r_select(r_select),
        .BAout(BAout), .PC_select(PC_select), .HI_select(HI_select), .LO_select(LO_select),
        .Z_HI_select(Z_HI_select), .Z_LO_select(Z_LO_select), .MDR_select(MDR_select),
        .InPort_select(InPort_select), .c_select(c_select), .alu_instruction(alu_instruction),
        .halted(halted)
    );

    always_comb begin
        obs = {PC_enable, PC_increment_enable, IR_enable, con_enable, Y_enable, Z_enable,
               MAR_enable, MDR_enable, HI_enable, LO_enable, read, write, Gra, Grb, Grc,
               r_enable, r_select, BAout, PC_select, HI_select, LO_select, Z_HI_select,
               Z_LO_select, MDR_select, InPort_select, c_select, alu_instruction, halted};
    end

    // Mid-cycle comparison of every control output against the expected step
    always @(negedge clk) begin
        if (exp_valid) begin
            n_chk++;
            trace.push_back(obs);
            if (obs === exp_v) n_pass++;
            else $display("FAIL %s: got %h want %h", step_name, obs, exp_v);
        end
    end

    task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL pin %s: got %h want %h", nm, got, want);
    endtask

    // Model: the full list of control steps an instruction produces, fetch included
    task automatic make_plan(input logic [4:0] op, input logic con);
        ctl_t s;
        bit   md;
`ifdef MUL_DIV_EN
        md = 1'b1;
`else
        md = 1'b0;
`endif
        plan.delete();
        s = '0; s.PC_select = 1; s.MAR_enable = 1; s.PC_increment_enable = 1; plan.push_back(s);
        s = '0; s.read = 1; s.MDR_enable = 1; plan.push_back(s);
        s = '0; s.MDR_select = 1; s.IR_enable = 1; plan.push_back(s);
        if (op >= 5'd3 && op <= 5'd14) begin
            s = '0; s.Grb = 1; s.r_select = 1; s.Y_enable = 1; plan.push_back(s);
            s = '0; s.Z_enable = 1;
            if (op <= 5'd11) begin
                s.Grc = 1; s.r_select = 1; s.alu = op;
            end else begin
                s.c_select = 1;
                s.alu = (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6;
            end
            plan.push_back(s);
            s = '0; s.Z_LO_select = 1; s.Gra = 1; s.r_enable = 1; plan.push_back(s);
        end else if (op == 5'd17 || op == 5'd18) begin
            s = '0; s.Grb = 1; s.r_select = 1; s.alu = op; s.Z_enable = 1; plan.push_back(s);
            s = '0; s.Z_LO_select = 1; s.Gra = 1; s.r_enable = 1; plan.push_back(s);
        end else if ((op == 5'd15 || op == 5'd16) && md) begin
            s = '0; s.Gra = 1; s.r_select = 1; s.Y_enable = 1; plan.push_back(s);
            s = '0; s.Grb = 1; s.r_select = 1; s.alu = op; s.Z_enable = 1; plan.push_back(s);
            s = '0; s.Z_LO_select = 1; s.LO_enable = 1; plan.push_back(s);
            s = '0; s.Z_HI_select = 1; s.HI_enable = 1; plan.push_back(s);
        end else if (op <= 5'd2) begin
            s = '0; s.Grb = 1; s.BAout = 1; s.Y_enable = 1; plan.push_back(s);
            s = '0; s.c_select = 1; s.alu = 5'd3; s.Z_enable = 1; plan.push_back(s);
            s = '0; s.Z_LO_select = 1;
            if (op == 5'd1) begin
                s.Gra = 1; s.r_enable = 1; plan.push_back(s);
            end else begin
                s.MAR_enable = 1; plan.push_back(s);
                s = '0; s.MDR_enable = 1;
                if (op == 5'd0) s.read = 1;
                else begin s.Gra = 1; s.r_select = 1; end
                plan.push_back(s);
                s = '0;
                if (op == 5'd0) begin s.MDR_select = 1; s.Gra = 1; s.r_enable = 1; end
                else s.write = 1;
                plan.push_back(s);
            end
        end else if (op == 5'd19) begin
            s = '0; s.Gra = 1; s.r_select = 1; s.con_enable = 1; plan.push_back(s);
            s = '0; s.PC_select = 1; s.Y_enable = 1; plan.push_back(s);
            s = '0; s.c_select = 1; s.alu = 5'd3; s.Z_enable = 1; plan.push_back(s);
            s = '0; s.Z_LO_select = 1; s.PC_enable = con; plan.push_back(s);
        end else if (op == 5'd20) begin
            s = '0; s.Gra = 1; s.r_select = 1; s.PC_enable = 1; plan.push_back(s);
        end else if (op == 5'd24 || op == 5'd25) begin
            s = '0; s.Gra = 1; s.r_enable = 1;
            if (op == 5'd24) s.HI_select = 1; else s.LO_select = 1;
            plan.push_back(s);
        end else if (op == 5'd27) begin
            s = '0; plan.push_back(s);
        end
    endtask

    task automatic run_instr(input string nm, input logic [31:0] ir, input logic con,
                             input int lat, input int limit);
        IR_Data    = ir;
        con_output = con;
        make_plan(ir[31:27], con);
        pin({nm, " latency"}, 32'(plan.size()), 32'(lat));
        trace.delete();
        for (int i = 0; i < plan.size() && i < limit; i++) begin
            step_name = $sformatf("%s T%0d", nm, i);
            exp_v     = plan[i];
            exp_valid = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_op(input string nm, input logic [4:0] op, input logic con, input int lat);
        run_instr(nm, {op, 27'($urandom)}, con, lat, 100);
    endtask

    initial begin
        int wr_cnt;
        clr        = 1'b0;
        IR_Data    = '0;
        con_output = 1'b0;
        exp_v      = '0;
        @(posedge clk); #1;
        step_name = "reset"; exp_valid = 1'b1; exp_v = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr = 1'b1;

        run_instr("add", 32'h19888000, 1'b0, 6, 100);
        pin("add T4", 32'({trace[4].alu, trace[4].Grc, trace[4].r_select, trace[4].Z_enable}), 32'h1F);
        pin("add T5", 32'({trace[5].Z_LO_select, trace[5].Gra, trace[5].r_enable}), 32'h7);
        run_op("sub", 5'b00100, 1'b1, 6);
        run_op("shl", 5'b01011, 1'b0, 6);
        run_op("addi", 5'b01100, 1'b0, 6);
        pin("addi T4 alu", 32'(trace[4].alu), 32'h3);
        run_op("andi", 5'b01101, 1'b1, 6);
        pin("andi T4 alu", 32'(trace[4].alu), 32'h5);
        run_op("ori", 5'b01110, 1'b0, 6);
        run_op("neg", 5'b10001, 1'b0, 5);
        run_op("not", 5'b10010, 1'b1, 5);
        run_op("ld", 5'b00000, 1'b1, 8);
        run_op("ldi", 5'b00001, 1'b0, 6);

        run_instr("st", 32'h10880025, 1'b0, 8, 100);
        pin("st T3 BAout", 32'(trace[3].BAout), 32'h1);
        pin("st T6 MDR/read", 32'({trace[6].MDR_enable, trace[6].read}), 32'h2);
        wr_cnt = 0;
        foreach (trace[i]) if (trace[i].write) wr_cnt++;
        pin("st write count", 32'(wr_cnt), 32'h1);
        pin("st T7 write", 32'(trace[7].write), 32'h1);

        run_op("br1", 5'b10011, 1'b1, 7);
        pin("br1 T6", 32'({trace[6].PC_enable, trace[6].Z_LO_select}), 32'h3);
        run_op("br0", 5'b10011, 1'b0, 7);
        pin("br0 T6", 32'({trace[6].PC_enable, trace[6].Z_LO_select}), 32'h1);
        run_op("jr", 5'b10100, 1'b0, 4);
        run_op("mfhi", 5'b11000, 1'b0, 4);
        run_op("mflo", 5'b11001, 1'b1, 4);
        run_op("jal", 5'b10101, 1'b0, 3);
        run_op("in", 5'b10110, 1'b1, 3);
        run_op("op26", 5'b11010, 1'b0, 3);
        run_op("op31", 5'b11111, 1'b0, 3);
`ifdef MUL_DIV_EN
        run_op("mul", 5'b10000, 1'b0, 7);
        pin("mul LO/HI", 32'({trace[5].LO_enable, trace[6].HI_enable}), 32'h3);
        run_op("div", 5'b01111, 1'b1, 7);
`else
        run_op("mul", 5'b10000, 1'b0, 3);
        run_op("div", 5'b01111, 1'b1, 3);
`endif

        // Reset asserted during ld T6
        run_instr("ld rst", {5'b00000, 27'h0123456}, 1'b1, 8, 6);
        clr = 1'b0; exp_v = '0; step_name = "reset mid-ld";
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr = 1'b1;
        run_op("after rst", 5'b00101, 1'b0, 6);
        pin("T0 after reset", 32'({trace[0].PC_select, trace[0].MAR_enable, trace[0].PC_increment_enable}), 32'h7);

        run_instr("halt", 32'hD8000000, 1'b0, 4, 100);
        exp_v = '0; exp_v.halted = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step_name  = $sformatf("halt hold %0d", i);
            con_output = i[0];
            @(posedge clk); #1;
        end
        pin("halted after T3", 32'(trace[4].halted), 32'h1);
        clr = 1'b0; exp_v = '0; step_name = "halt clr";
        @(posedge clk); #1;
        clr = 1'b1;
        run_instr("add2", 32'h19888000, 1'b1, 6, 100);
        exp_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
